// File: rtl/vrased_rst_seq.sv
// vrased_rst_seq: stretches per-monitor violation requests into a registered CPU reset and records cause, PC and episode count
module vrased_rst_seq #(
    parameter int STRETCH = 4,
    parameter int CNT_W   = 8,
    parameter int NSRC    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NSRC-1:0]  viol,
    input  logic [15:0]      pc,
    input  logic             clr,
    output logic             cpu_rst,
    output logic [NSRC-1:0]  cause,
    output logic [15:0]      viol_pc,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       any_viol;

    assign any_viol = |viol;
    assign busy     = cpu_rst;

    // episode FSM: capture on entry, hold for the stretch time, then wait for all requests to drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cpu_rst  <= 1'b0;
            cause    <= '0;
            viol_pc  <= '0;
            viol_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_viol) begin
                        state    <= HOLD;
                        cpu_rst  <= 1'b1;
                        cnt      <= 8'(STRETCH - 1);
                        cause    <= viol;
                        viol_pc  <= pc;
                        viol_cnt <= (&viol_cnt) ? viol_cnt : viol_cnt + CNT_W'(1);
                    end else if (clr) begin
                        cause   <= '0;
                        viol_pc <= '0;
                    end
                end
                HOLD: begin
                    cause <= cause | viol;
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (any_viol) begin
                        state <= WAIT;
                    end else begin
                        state   <= IDLE;
                        cpu_rst <= 1'b0;
                    end
                end
                WAIT: begin
                    cause <= cause | viol;
                    if (!any_viol) begin
                        state   <= IDLE;
                        cpu_rst <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cpu_rst <= 1'b0;
                end
            endcase
        end
    end
endmodule
